// File: rtl/pe_pkg.sv
// pe_pkg: shared fixed-point helpers for the processing-element array.
package pe_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_FRAC  = 0;
   localparam int MAXW      = 64;
   typedef logic signed [MAXW-1:0] wide_t;
   function automatic wide_t smax(input int w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction
   function automatic wide_t smin(input int w);
      return -(wide_t'(1) <<< (w - 1));
   endfunction
   function automatic wide_t clamp(input wide_t v, input int w);
      return v > smax(w) ? smax(w) : v < smin(w) ? smin(w) : v;
   endfunction
   // half-LSB of the output format, added before the shift for round half-up
   function automatic wide_t rnd_const(input int f);
      return f > 0 ? wide_t'(1) <<< (f - 1) : '0;
   endfunction
   localparam wide_t DEF_MAX = smax(DEF_WIDTH);
   localparam wide_t DEF_MIN = smin(DEF_WIDTH);
endpackage

// File: rtl/pe_fixmul_sat.sv
// pe_fixmul_sat: combinational y + scale(a*b) with optional rounding and saturation.
module pe_fixmul_sat
   import pe_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC_BIT = DEF_FRAC
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   input  logic signed [WIDTH-1:0] y,
   input  logic                    rnd_en,
   input  logic                    sat_en,
   output logic signed [WIDTH-1:0] result,
   output logic                    ovf_raw
);
   localparam int PW = 2 * WIDTH;
   localparam wide_t YMAX = smax(WIDTH);
   localparam wide_t YMIN = smin(WIDTH);
   logic signed [PW-1:0] p, pr, s, rc;
   logic signed [PW:0]   r;
   wide_t                rw;
   assign rc      = PW'(rnd_const(FRAC_BIT));
   assign p       = a * b;
   assign pr      = p + (rnd_en ? rc : '0);
   assign s       = pr >>> FRAC_BIT;
   assign r       = (PW+1)'(y) + (PW+1)'(s);
   assign rw      = wide_t'(r);
   assign ovf_raw = rw > YMAX || rw < YMIN;
   assign result  = sat_en ? WIDTH'(clamp(rw, WIDTH)) : r[WIDTH-1:0];
endmodule

// File: rtl/pe_pipe.sv
// pe_pipe: registered systolic PE with double-buffered weight, rounding,
// saturation and a sticky overflow flag.
module pe_pipe
   import pe_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC_BIT = DEF_FRAC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] y_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] y_out,
   input  logic             b_wr,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] b_out,
   input  logic             b_swap,
   input  logic             rnd_en,
   input  logic             sat_en,
   output logic             ovf,
   input  logic             ovf_clr
);
   logic [WIDTH-1:0] shadow, active, res;
   logic             ovf_raw, acc;
   pe_fixmul_sat #(.WIDTH(WIDTH), .FRAC_BIT(FRAC_BIT)) u_mul (
      .a(a_in), .b(active), .y(y_in), .rnd_en(rnd_en), .sat_en(sat_en),
      .result(res), .ovf_raw(ovf_raw)
   );
   assign acc   = en && valid_in;
   assign b_out = shadow;
   // the datapath reads the pre-edge active weight, so a sample on a swap edge uses the old one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         a_out     <= '0;
         y_out     <= '0;
         shadow    <= '0;
         active    <= '0;
         ovf       <= 1'b0;
      end else begin
         if (b_wr) shadow <= b_in;
         if (b_swap) active <= shadow;
         if (en) valid_out <= valid_in;
         if (acc) begin
            a_out <= a_in;
            y_out <= res;
         end
         if (acc && ovf_raw) ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pe_pipe.sv
// tb_pe_pipe: two chained PEs checked against an integer model via a scoreboard.
module tb_pe_pipe;
   localparam int W = 8;
   localparam int F = 4;
   logic clk = 0, rst = 1;
   logic en = 0, valid_in = 0, b_wr = 0, b_swap = 0, rnd_en = 0, sat_en = 0, ovf_clr = 0;
   logic [7:0] a_in = 0, y_in = 0, b_src = 0;
   logic v0, v1, ov0, ov1;
   logic [7:0] a0, a1, y0, y1, bo0, bo1;
   typedef struct {logic [7:0] y0; logic [7:0] y1; logic [7:0] a;} exp_t;
   exp_t sb[$];
   int total = 0, bad = 0;
   logic [7:0] sh0 = 0, sh1 = 0, ac0 = 0, ac1 = 0, ey0 = 0, ey1 = 0, ea = 0;
   logic ev = 0, eo0 = 0, eo1 = 0;

   always #5 clk = ~clk;

   pe_pipe #(.WIDTH(W), .FRAC_BIT(F)) u0 (
      .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .a_in(a_in), .y_in(y_in),
      .valid_out(v0), .a_out(a0), .y_out(y0), .b_wr(b_wr), .b_in(b_src), .b_out(bo0),
      .b_swap(b_swap), .rnd_en(rnd_en), .sat_en(sat_en), .ovf(ov0), .ovf_clr(ovf_clr)
   );
   pe_pipe #(.WIDTH(W), .FRAC_BIT(F)) u1 (
      .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .a_in(a_in), .y_in(y_in),
      .valid_out(v1), .a_out(a1), .y_out(y1), .b_wr(b_wr), .b_in(bo0), .b_out(bo1),
      .b_swap(b_swap), .rnd_en(rnd_en), .sat_en(sat_en), .ovf(ov1), .ovf_clr(ovf_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] mdl(input logic [7:0] a, b, y, input logic rnd, sat);
      int p, r, c;
      p = $signed(a) * $signed(b);
      if (rnd) p += 1 << (F - 1);
      p = p >>> F;
      r = $signed(y) + p;
      c = r > 127 ? 127 : r < -128 ? -128 : r;
      c = sat ? c : r;
      return {r > 127 || r < -128, c[7:0]};
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_v0"}, v0, ev);
      check({tag, "_v1"}, v1, ev);
      check({tag, "_a0"}, a0, ea);
      check({tag, "_a1"}, a1, ea);
      check({tag, "_y0"}, y0, ey0);
      check({tag, "_y1"}, y1, ey1);
      check({tag, "_ovf0"}, ov0, eo0);
      check({tag, "_ovf1"}, ov1, eo1);
      check({tag, "_bout0"}, bo0, sh0);
      check({tag, "_bout1"}, bo1, sh1);
   endtask

   task automatic tick(input string tag);
      logic [8:0] m0, m1;
      logic acc;
      exp_t e;
      acc = en && valid_in;
      m0 = mdl(a_in, ac0, y_in, rnd_en, sat_en);
      m1 = mdl(a_in, ac1, y_in, rnd_en, sat_en);
      if (acc) sb.push_back('{m0[7:0], m1[7:0], a_in});
      @(posedge clk);
      #1;
      eo0 = (acc && m0[8]) ? 1'b1 : ovf_clr ? 1'b0 : eo0;
      eo1 = (acc && m1[8]) ? 1'b1 : ovf_clr ? 1'b0 : eo1;
      if (b_swap) begin
         ac0 = sh0;
         ac1 = sh1;
      end
      if (b_wr) begin
         sh1 = sh0;
         sh0 = b_src;
      end
      if (en) ev = valid_in;
      if (acc) begin
         e = sb.pop_front();
         ey0 = e.y0;
         ey1 = e.y1;
         ea  = e.a;
      end
      check_all(tag);
   endtask

   task automatic drive(input logic e, v, input logic [7:0] a, y);
      en = e;
      valid_in = v;
      a_in = a;
      y_in = y;
   endtask

   task automatic load(input logic [7:0] b);
      drive(1, 0, 0, 0);
      b_wr = 1;
      b_src = b;
      tick("ld_wr");
      b_wr = 0;
      b_swap = 1;
      tick("ld_swap");
      b_swap = 0;
   endtask

   task automatic model_reset();
      sh0 = 0; sh1 = 0; ac0 = 0; ac1 = 0; ey0 = 0; ey1 = 0; ea = 0;
      ev = 0; eo0 = 0; eo1 = 0;
      sb.delete();
   endtask

   initial begin
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 0;
      // basic MAC
      load(8'h18);
      drive(1, 1, 8'h20, 8'h10);
      tick("mac");
      check("mac_spec_y", y0, 8'h40);
      // rounding vs truncation
      load(8'h08);
      rnd_en = 1; drive(1, 1, 8'h01, 8'h00); tick("rnd1");
      check("rnd1_spec", y0, 8'h01);
      rnd_en = 0; tick("trn1");
      check("trn1_spec", y0, 8'h00);
      rnd_en = 1; drive(1, 1, 8'hFF, 8'h00); tick("rndm1");
      check("rndm1_spec", y0, 8'h00);
      rnd_en = 0; tick("trnm1");
      check("trnm1_spec", y0, 8'hFF);
      // overflow, saturate and wrap
      load(8'h7F);
      sat_en = 1; drive(1, 1, 8'h7F, 8'h7F); tick("sat");
      check("sat_spec", y0, 8'h7F);
      check("sat_ovf_spec", ov0, 1'b1);
      sat_en = 0; tick("wrap");
      check("wrap_spec", y0, 8'h6F);
      drive(1, 0, 0, 0); ovf_clr = 1; tick("clr");
      check("clr_spec", ov0, 1'b0);
      drive(1, 1, 8'h7F, 8'h7F); tick("clr_set");
      check("clr_set_spec", ov0, 1'b1);
      ovf_clr = 0;
      // chain shift and swap with a sample on the swap edge
      drive(1, 0, 0, 0);
      b_wr = 1; b_src = 8'h10; tick("ch1");
      b_src = 8'h20; tick("ch2");
      b_wr = 0; b_swap = 1; drive(1, 1, 8'h10, 8'h00); tick("ch_swap");
      check("swap_old_w0", y0, 8'h7F);
      b_swap = 0; tick("ch_new");
      check("chain_w0", y0, 8'h20);
      check("chain_w1", y1, 8'h10);
      // stall and bubble
      drive(1, 1, 8'h11, 8'h01); tick("st_s1");
      drive(0, 1, 8'h22, 8'h02); tick("st_hold1");
      tick("st_hold2");
      drive(1, 1, 8'h22, 8'h02); tick("st_s2");
      drive(1, 0, 8'h55, 8'h55); tick("st_bub");
      drive(1, 1, 8'h33, 8'h03); tick("st_s3");
      drive(1, 0, 0, 0); tick("st_idle");
      check("sb_drained", sb.size(), 0);
      // asynchronous reset between edges
      drive(1, 1, 8'h44, 8'h04); tick("pre_rst");
      #3 rst = 1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 0;
      drive(1, 1, 8'h12, 8'h33); tick("post_rst");
      check("post_rst_spec", y0, 8'h33);
      // random traffic
      for (int i = 0; i < 80; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
         b_wr = $urandom_range(0, 3) == 0;
         b_swap = $urandom_range(0, 4) == 0;
         b_src = 8'($urandom);
         rnd_en = 1'($urandom);
         sat_en = 1'($urandom);
         ovf_clr = $urandom_range(0, 5) == 0;
         tick("rand");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pe_pipe.md
Name: pe_pipe

Overview:
Registered, parametrised processing element for the systolic matrix-vector array. Each cycle it computes y_out = y_in + scale(a_in * b) in signed fixed point and passes a_in through to the neighbouring PE. Compared with the combinational PE it adds:
- one-cycle pipelining with a valid/stall scheme
- a double-buffered (shadow/active) weight register that can be shift-loaded through a column
- runtime-selectable rounding and saturation
- a sticky overflow flag

Parameters:
WIDTH, 8, data/weight width, signed two's complement
FRAC_BIT, 0, fractional bits of the fixed-point format; legal 0..WIDTH-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  pipeline enable; 0 = stall, data/valid registers hold
valid_in  input  1  a_in/y_in qualify this cycle
a_in  input  WIDTH  signed activation
y_in  input  WIDTH  signed partial sum from the upstream PE
valid_out  output  1  a_out/y_out qualify
a_out  output  WIDTH  registered copy of a_in
y_out  output  WIDTH  registered partial sum
b_wr  input  1  shift/write enable for the shadow weight
b_in  input  WIDTH  shadow weight input (from b_out of the previous PE in the chain)
b_out  output  WIDTH  current shadow weight (feeds the next PE in the chain)
b_swap  input  1  copy shadow weight into active weight
rnd_en  input  1  1 = round half-up at FRAC_BIT; 0 = truncate (arithmetic shift)
sat_en  input  1  1 = saturate result; 0 = wrap
ovf  output  1  sticky overflow flag
ovf_clr  input  1  clear ovf

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): valid_out=0, a_out=0, y_out=0, shadow=0, active=0, ovf=0.
- Latency: 1 cycle. A sample accepted at edge t (en=1, valid_in=1) appears on a_out/y_out with valid_out=1 after edge t.
- en=1, valid_in=0: valid_out←0; a_out/y_out hold their last values.
- en=0: valid_out, a_out and y_out all hold. Weight registers and ovf are unaffected by en.
- Weights:
  - b_wr=1: shadow←b_in.
  - b_swap=1: active←shadow (pre-edge value).
  - b_wr and b_swap together: active gets the old shadow and shadow gets b_in.
  - A sample accepted on the same edge as b_swap uses the old active weight.
  - b_out=shadow, registered.
- Arithmetic, using the active weight:
  - p = a_in*b, 2*WIDTH signed.
  - If rnd_en=1 and FRAC_BIT>0: p += 2^(FRAC_BIT-1).
  - s = p >>> FRAC_BIT (arithmetic shift).
  - r = y_in + s, computed at full precision (2*WIDTH+1 bits).
  - sat_en=1: r is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - sat_en=0: y_out = r[WIDTH-1:0] (wrap). This equals y_in + s[WIDTH-1:0] modulo 2^WIDTH, which matches the legacy PE when rnd_en=0.
- ovf:
  - Set on any accepted sample whose full-precision r lies outside the WIDTH range, regardless of sat_en.
  - ovf_clr=1 clears it.
  - ovf_clr and a new overflow on the same edge: set wins (ovf=1).
- rnd_en and sat_en are sampled with the data on the accepting edge; changing them between samples is legal.

Decomposition:
- Shared package pe_pkg:
  - saturating-clamp function, parametrised by width
  - round-constant helper
  - localparams for the WIDTH min/max values
- Natural sub-module pe_fixmul_sat: combinational block (a, b, y, rnd_en, sat_en → result, ovf_raw).
- pe_pipe instantiates pe_fixmul_sat plus the valid/data pipeline, the weight registers and the flag logic.

Test Plan (WIDTH=8, FRAC_BIT=4 unless noted):
- Basic MAC:
  - load b=0x18 (b_wr, then b_swap); a_in=0x20, y_in=0x10, valid_in=1.
  - Expect y_out=0x40, a_out=0x20, valid_out=1 one cycle later, ovf=0.
- Rounding: b=0x08, a_in=0x01, y_in=0 → y_out=0x01 (rnd_en=1) / 0x00 (rnd_en=0); a_in=0xFF → 0x00 / 0xFF.
- Overflow:
  - b=0x7F, a_in=0x7F, y_in=0x7F, sat_en=1 → y_out=0x7F, ovf=1.
  - Same with sat_en=0 → y_out=0x6F, ovf=1.
  - ovf_clr pulse → ovf=0.
  - ovf_clr coincident with a new overflow → ovf stays 1.
- Weight double-buffer and chain:
  - Two PEs chained via b_out→b_in; shift in 0x10 then 0x20 with b_wr, then b_swap.
  - Expect active weights 0x10 (second PE) and 0x20 (first PE).
  - A sample accepted on the swap edge uses the old weights.
- Stall/bubble: stream 3 samples with en=0 for 2 cycles mid-stream and valid_in=0 for 1 cycle → outputs/valid hold during the stall, valid_out=0 for the bubble, no sample lost or duplicated.
- Async reset: assert rst mid-stream between edges → all outputs 0 immediately; after release the first accepted sample uses active weight 0 (y_out=y_in).
